// File: rtl/traffic_pkg.sv
// Shared lamp/fault encodings for the traffic controller and its safety checker.
package traffic_pkg;

  localparam logic [1:0] LAMP_RED     = 2'b00;
  localparam logic [1:0] LAMP_YELLOW  = 2'b01;
  localparam logic [1:0] LAMP_GREEN   = 2'b10;
  localparam logic [1:0] LAMP_ILLEGAL = 2'b11;

  localparam logic [2:0] FLT_NONE         = 3'd0;
  localparam logic [2:0] FLT_ILLEGAL      = 3'd1;
  localparam logic [2:0] FLT_CONFLICT     = 3'd2;
  localparam logic [2:0] FLT_SEQ          = 3'd3;
  localparam logic [2:0] FLT_SHORT_GREEN  = 3'd4;
  localparam logic [2:0] FLT_SHORT_YELLOW = 3'd5;
  localparam logic [2:0] FLT_STARVE       = 3'd6;

  typedef enum logic [1:0] {
    CHK_IDLE  = 2'd0,
    CHK_ARM   = 2'd1,
    CHK_CHECK = 2'd2
  } chk_state_e;

  // Only hold, R->G, G->Y and Y->R are legal lamp steps.
  function automatic logic step_legal(input logic [1:0] prev, input logic [1:0] cur);
    return (cur == prev) ||
           (prev == LAMP_RED    && cur == LAMP_GREEN)  ||
           (prev == LAMP_GREEN  && cur == LAMP_YELLOW) ||
           (prev == LAMP_YELLOW && cur == LAMP_RED);
  endfunction

  // Road number (1..3) of the lowest set flag, 0 when none is set.
  function automatic logic [1:0] first_road(input logic [2:0] v);
    if (v[0]) return 2'd1;
    if (v[1]) return 2'd2;
    if (v[2]) return 2'd3;
    return 2'd0;
  endfunction

endpackage

// File: rtl/lamp_track.sv
// Per-road tracker: remembers the previous lamp and how long it has been held,
// and flags the per-road rule violations for the current sample.
module lamp_track
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_RED    = 64,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm_i,
  input  logic       check_i,
  input  logic       flush_i,
  input  logic [1:0] lamp_i,
  output logic       illegal_o,
  output logic       seq_o,
  output logic       short_green_o,
  output logic       short_yellow_o,
  output logic       starve_o,
  output logic       g2y_o
);

  localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_R = CNT_W'(MAX_RED);

  logic [1:0]       lamp_q, lamp_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             hold, g2y, y2r, r2r;

  // Violation flags for the current sample against the stored history.
  always_comb begin
    hold           = (lamp_i == lamp_q);
    g2y            = (lamp_q == LAMP_GREEN)  && (lamp_i == LAMP_YELLOW);
    y2r            = (lamp_q == LAMP_YELLOW) && (lamp_i == LAMP_RED);
    r2r            = (lamp_q == LAMP_RED)    && (lamp_i == LAMP_RED);
    illegal_o      = check_i && (lamp_i == LAMP_ILLEGAL);
    seq_o          = check_i && !step_legal(lamp_q, lamp_i);
    short_green_o  = check_i && g2y && (dwell_q < MIN_G);
    short_yellow_o = check_i && y2r && (dwell_q < MIN_Y);
    // Red held once more would push the dwell past the limit.
    starve_o       = check_i && r2r && (dwell_q >= MAX_R);
    g2y_o          = check_i && g2y;
  end

  // Next previous-lamp and saturating dwell count.
  always_comb begin
    lamp_d  = lamp_q;
    dwell_d = dwell_q;
    if (arm_i) begin
      lamp_d  = lamp_i;
      dwell_d = CNT_W'(1);
    end else if (check_i) begin
      lamp_d = lamp_i;
      if (!hold)                dwell_d = CNT_W'(1);
      else if (dwell_q != '1)   dwell_d = dwell_q + CNT_W'(1);
    end else if (flush_i) begin
      dwell_d = '0;
    end
  end

  // History registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lamp_q  <= LAMP_RED;
      dwell_q <= '0;
    end else begin
      lamp_q  <= lamp_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/traffic_light_checker.sv
// Safety monitor for the 3-way traffic controller: sticky first-fault capture
// with cause/road, plus a count of green->yellow phase ends.
//
// state     | meaning
// CHK_IDLE  | not checking; waits for start
// CHK_ARM   | one cycle: capture current lamps as history, dwell = 1
// CHK_CHECK | evaluate all rules each cycle; start low returns to idle
module traffic_light_checker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_RED    = 64,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic [1:0]       l1,
  input  logic [1:0]       l2,
  input  logic [1:0]       l3,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [1:0]       fault_road,
  output logic [CNT_W-1:0] phase_count
);

  chk_state_e       state_q, state_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic [1:0]       road_q, road_d;
  logic [CNT_W-1:0] phase_q, phase_d;

  logic [1:0] lamp [3];
  logic [2:0] illegal, seq, short_g, short_y, starve, g2y, non_red;
  logic       arm, check_en, flush, conflict;
  logic [2:0] viol_code;
  logic [1:0] viol_road;

  assign lamp[0]  = l1;
  assign lamp[1]  = l2;
  assign lamp[2]  = l3;
  assign arm      = (state_q == CHK_ARM);
  assign check_en = (state_q == CHK_CHECK) && start;
  assign flush    = (state_q == CHK_CHECK) && !start;

  for (genvar i = 0; i < 3; i++) begin : g_road
    assign non_red[i] = (lamp[i] != LAMP_RED);
    lamp_track #(
      .MIN_GREEN (MIN_GREEN),
      .MIN_YELLOW(MIN_YELLOW),
      .MAX_RED   (MAX_RED),
      .CNT_W     (CNT_W)
    ) u_track (
      .clk           (clk),
      .rst           (rst),
      .arm_i         (arm),
      .check_i       (check_en),
      .flush_i       (flush),
      .lamp_i        (lamp[i]),
      .illegal_o     (illegal[i]),
      .seq_o         (seq[i]),
      .short_green_o (short_g[i]),
      .short_yellow_o(short_y[i]),
      .starve_o      (starve[i]),
      .g2y_o         (g2y[i])
    );
  end

  // More than one bit set in non_red means two roads are showing a colour.
  assign conflict = check_en && ((non_red & (non_red - 3'd1)) != 3'd0);

  // Pick the highest-priority violation: lowest code, then lowest road.
  always_comb begin
    viol_code = FLT_NONE;
    viol_road = 2'd0;
    if (|illegal) begin
      viol_code = FLT_ILLEGAL;
      viol_road = first_road(illegal);
    end else if (conflict) begin
      viol_code = FLT_CONFLICT;
    end else if (|seq) begin
      viol_code = FLT_SEQ;
      viol_road = first_road(seq);
    end else if (|short_g) begin
      viol_code = FLT_SHORT_GREEN;
      viol_road = first_road(short_g);
    end else if (|short_y) begin
      viol_code = FLT_SHORT_YELLOW;
      viol_road = first_road(short_y);
    end else if (|starve) begin
      viol_code = FLT_STARVE;
      viol_road = first_road(starve);
    end
  end

  // Next state, sticky fault capture (a new violation beats clr) and phase count.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    road_d  = road_q;
    phase_d = phase_q + CNT_W'(g2y[0]) + CNT_W'(g2y[1]) + CNT_W'(g2y[2]);
    unique case (state_q)
      CHK_IDLE:  if (start) state_d = CHK_ARM;
      CHK_ARM:   state_d = CHK_CHECK;
      CHK_CHECK: if (!start) state_d = CHK_IDLE;
      default:   state_d = CHK_IDLE;
    endcase
    if ((viol_code != FLT_NONE) && (!fault_q || clr)) begin
      fault_d = 1'b1;
      code_d  = viol_code;
      road_d  = viol_road;
    end else if (clr) begin
      fault_d = 1'b0;
      code_d  = FLT_NONE;
      road_d  = 2'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CHK_IDLE;
      fault_q <= 1'b0;
      code_q  <= FLT_NONE;
      road_q  <= 2'd0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      road_q  <= road_d;
      phase_q <= phase_d;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_road  = road_q;
  assign phase_count = phase_q;

endmodule

// File: tb/tb_traffic_light_checker.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs; an independent monitor pops and compares after every clock edge.
module tb_traffic_light_checker;

  localparam int R = 0, Y = 1, G = 2, X = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, clr = 1'b0;
  logic [1:0] l1 = 2'd0, l2 = 2'd0, l3 = 2'd0;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_road;
  logic [7:0] phase_count;

  traffic_light_checker #(
    .MIN_GREEN(4), .MIN_YELLOW(2), .MAX_RED(64), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr),
    .l1(l1), .l2(l2), .l3(l3),
    .fault(fault), .fault_code(fault_code), .fault_road(fault_road),
    .phase_count(phase_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f;
    int c;
    int r;
    int pc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: monitoring mode plus the full lamp history since arming.
  bit   m_on;        // start seen, waiting for the capture cycle
  bit   m_watch;     // history captured, rules apply
  int   hist[3][$];
  int   m_f, m_c, m_r, m_pc;

  function automatic int run_len(input int r);
    int n = 0;
    int last = hist[r][hist[r].size()-1];
    for (int i = hist[r].size()-1; i >= 0; i--) begin
      if (hist[r][i] != last) break;
      n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  function automatic int lowest(input bit [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit c, input int la[3]);
    int vc, vr, nonred, prev, run, cur;
    bit [2:0] ill, sq, sg, sy, st;
    vc = 0; vr = 0; nonred = 0; ill = 0; sq = 0; sg = 0; sy = 0; st = 0;
    if (!r) begin
      m_f = 0; m_c = 0; m_r = 0; m_pc = 0; m_on = 0; m_watch = 0;
      for (int k = 0; k < 3; k++) hist[k].delete();
      return;
    end
    if (m_watch && s) begin
      for (int k = 0; k < 3; k++) begin
        prev = hist[k][hist[k].size()-1];
        run  = run_len(k);
        cur  = la[k];
        if (cur != R) nonred++;
        ill[k] = (cur == X);
        sq[k]  = !(cur == prev || (prev == R && cur == G) ||
                   (prev == G && cur == Y) || (prev == Y && cur == R));
        sg[k]  = (prev == G && cur == Y && run < 4);
        sy[k]  = (prev == Y && cur == R && run < 2);
        st[k]  = (prev == R && cur == R && run + 1 > 64);
        if (prev == G && cur == Y) m_pc = (m_pc + 1) % 256;
        hist[k].push_back(cur);
        if (hist[k].size() > 300) void'(hist[k].pop_front());
      end
      if (ill != 0)        begin vc = 1; vr = lowest(ill); end
      else if (nonred > 1) begin vc = 2; vr = 0; end
      else if (sq != 0)    begin vc = 3; vr = lowest(sq); end
      else if (sg != 0)    begin vc = 4; vr = lowest(sg); end
      else if (sy != 0)    begin vc = 5; vr = lowest(sy); end
      else if (st != 0)    begin vc = 6; vr = lowest(st); end
    end else if (m_watch) begin
      m_watch = 0;
      for (int k = 0; k < 3; k++) hist[k].delete();
    end else if (m_on) begin
      m_on = 0;
      m_watch = 1;
      for (int k = 0; k < 3; k++) begin
        hist[k].delete();
        hist[k].push_back(la[k]);
      end
    end else if (s) begin
      m_on = 1;
    end
    if (vc != 0 && (m_f == 0 || c)) begin
      m_f = 1; m_c = vc; m_r = vr;
    end else if (c) begin
      m_f = 0; m_c = 0; m_r = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit c,
                     input int a, input int b, input int d);
    int   la[3];
    exp_t e;
    @(negedge clk);
    rst = r; start = s; clr = c;
    l1 = 2'(a); l2 = 2'(b); l3 = 2'(d);
    la[0] = a; la[1] = b; la[2] = d;
    model_step(r, s, c, la);
    e.f = m_f; e.c = m_c; e.r = m_r; e.pc = m_pc;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs just after each edge against the oldest entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("fault",       int'(fault),       e.f);
      chk("fault_code",  int'(fault_code),  e.c);
      chk("fault_road",  int'(fault_road),  e.r);
      chk("phase_count", int'(phase_count), e.pc);
    end
  end

  // Leave the checker idle with any fault cleared, then re-arm on all-red.
  task automatic rearm();
    cyc(1, 0, 1, R, R, R);
    cyc(1, 1, 0, R, R, R);
    cyc(1, 1, 0, R, R, R);
    cyc(1, 1, 0, R, R, R);
  endtask

  task automatic emit(input int road, input int colour);
    int la[3];
    int k;
    bit r, s, c;
    la[0] = R; la[1] = R; la[2] = R;
    if (road >= 0) la[road] = colour;
    if ($urandom_range(0, 79) == 0) begin
      k = $urandom_range(0, 2);
      la[k] = $urandom_range(0, 3);
    end
    r = ($urandom_range(0, 499) != 0);
    s = ($urandom_range(0, 299) != 0);
    c = ($urandom_range(0, 39) == 0);
    cyc(r, s, c, la[0], la[1], la[2]);
  endtask

  task automatic run_random();
    int road, g, y, gap;
    for (int p = 0; p < 150; p++) begin
      road = $urandom_range(0, 2);
      g    = $urandom_range(2, 7);
      y    = $urandom_range(1, 3);
      gap  = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 3);
      for (int i = 0; i < g; i++)   emit(road, G);
      for (int i = 0; i < y; i++)   emit(road, Y);
      for (int i = 0; i < gap; i++) emit(-1, R);
    end
  endtask

  initial begin
    // Reset, arm on all-red, hold until red starvation on road 1.
    repeat (2) cyc(0, 0, 0, R, R, R);
    repeat (70) cyc(1, 1, 0, R, R, R);
    // Legal full phase on road 1.
    rearm();
    repeat (5) cyc(1, 1, 0, G, R, R);
    repeat (2) cyc(1, 1, 0, Y, R, R);
    repeat (3) cyc(1, 1, 0, R, R, R);
    // Conflict, then a sticky follow-up violation, then clr coincident with it.
    cyc(1, 1, 0, G, Y, R);
    cyc(1, 1, 0, X, R, R);
    cyc(1, 1, 1, X, R, R);
    cyc(1, 1, 0, X, R, R);
    // Road 2 skips green.
    rearm();
    cyc(1, 1, 0, R, Y, R);
    cyc(1, 1, 0, R, Y, R);
    // Road 3 short green.
    rearm();
    repeat (2) cyc(1, 1, 0, R, R, G);
    cyc(1, 1, 0, R, R, Y);
    cyc(1, 1, 0, R, R, Y);
    // Short green coincident with an illegal code on road 1.
    rearm();
    repeat (2) cyc(1, 1, 0, R, R, G);
    cyc(1, 1, 0, X, R, Y);
    // Short yellow on road 2 after a clean green.
    rearm();
    repeat (4) cyc(1, 1, 0, R, G, R);
    cyc(1, 1, 0, R, Y, R);
    cyc(1, 1, 0, R, R, R);
    // Plain clr with no violation, then mid-run reset while faulted.
    cyc(1, 1, 1, R, R, R);
    cyc(1, 1, 0, R, Y, R);
    cyc(1, 1, 0, R, Y, R);
    cyc(0, 1, 0, R, Y, R);
    cyc(1, 1, 0, R, R, R);
    cyc(1, 1, 0, R, R, R);
    // Randomized controller-like traffic with injected glitches.
    run_random();
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
